// File: rtl/predict_pkg.sv
// predict_pkg: shared definitions for the branch predictor write side.
// Entry layout {valid, state, tag, target}, field widths, the 2-bit
// counter encoding, and the per-lane next-entry evaluation used by the
// update path.
package predict_pkg;

    localparam int VALID_BIT = 17;
    localparam int STATE_HI  = 16;
    localparam int STATE_LO  = 15;
    localparam int TAG_HI    = 14;
    localparam int TAG_LO    = 13;
    localparam int TGT_HI    = 12;
    localparam int TGT_LO    = 0;

    localparam int IDX_W   = 11;
    localparam int TAG_W   = 2;
    localparam int PC_W    = 13;
    localparam int ENTRY_W = 18;
    localparam int UPD_W   = IDX_W + ENTRY_W;   // queued {addr, data}

    typedef enum logic [1:0] {
        ST_SNT = 2'd0,
        ST_WNT = 2'd1,
        ST_WT  = 2'd2,
        ST_ST  = 2'd3
    } ctr_e;

    typedef struct packed {
        logic               wr;
        logic [ENTRY_W-1:0] entry;
    } lane_res_t;

    // Next table entry for one resolved branch given its lookup values.
    // wr=0 when nothing needs writing: a not-taken miss, or a hit whose
    // updated entry is identical to the one already in the table.
    function automatic lane_res_t eval_lane(
        input logic             match,
        input logic [1:0]       state,
        input logic [PC_W-1:0]  pretgt,
        input logic             taken,
        input logic [PC_W-1:0]  target,
        input logic [TAG_W-1:0] tag
    );
        lane_res_t       r;
        logic [1:0]      ns;
        logic [PC_W-1:0] nt;
        r.wr    = 1'b0;
        r.entry = '0;
        ns      = state;
        nt      = pretgt;
        if (!match) begin
            if (taken) begin
                r.wr    = 1'b1;
                r.entry = {1'b1, 2'(ST_WT), tag, target};
            end
        end else begin
            if (taken) begin
                ns = (state == 2'(ST_ST)) ? 2'(ST_ST) : state + 2'd1;
                nt = target;
            end else begin
                ns = (state == 2'(ST_SNT)) ? 2'(ST_SNT) : state - 2'd1;
                nt = pretgt;
            end
            r.entry = {1'b1, ns, tag, nt};
            r.wr    = (ns != state) || (nt != pretgt);
        end
        return r;
    endfunction

endpackage

// File: rtl/pu_fifo.sv
// pu_fifo: DEPTH-entry queue of {addr, data} table updates.
// Ports: CLK/RST (async active-high); push1/din1 and push2/din2 enqueue up
// to two entries per cycle (din1 lands first, push2 is only used together
// with push1); pop dequeues the head shown on dout; empty flags no entries;
// free is the slot count available this cycle, already counting the slot
// released by a concurrent pop.
module pu_fifo
    import predict_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push1,
    input  logic [UPD_W-1:0]       din1,
    input  logic                   push2,
    input  logic [UPD_W-1:0]       din2,
    input  logic                   pop,
    output logic [UPD_W-1:0]       dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UPD_W-1:0] mem_q [DEPTH];
    logic [UPD_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_pop;

    always_comb begin
        mem_d  = mem_q;
        do_pop = pop && (cnt_q != '0);
        if (push1) begin
            mem_d[wr_q] = din1;
        end
        if (push2) begin
            mem_d[push1 ? wr_q + AW'(1) : wr_q] = din2;
        end
        // Power-of-two depth: pointers wrap by plain overflow.
        wr_d  = wr_q + AW'(push1) + AW'(push2);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + CW'(push1) + CW'(push2) - CW'(do_pop);
        dout  = mem_q[rd_q];
        empty = (cnt_q == '0);
        free  = CW'(DEPTH) - cnt_q + CW'(do_pop);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/predict_update.sv
// predict_update: write side of the branch predictor table.
// Ports: CLK/RST (async active-high); per-lane resolved branch info
// e_valid/e_pc/e_taken/e_target plus lookup-time e_match/e_state/e_pretgt
// (lane 1 older); w_addr/w_data/wen drive the table's single write port;
// drop pulses for one cycle when an update could not be queued.
module predict_update
    import predict_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         e_valid1,
    input  logic [12:0]  e_pc1,
    input  logic         e_taken1,
    input  logic [12:0]  e_target1,
    input  logic         e_match1,
    input  logic [1:0]   e_state1,
    input  logic [12:0]  e_pretgt1,
    input  logic         e_valid2,
    input  logic [12:0]  e_pc2,
    input  logic         e_taken2,
    input  logic [12:0]  e_target2,
    input  logic         e_match2,
    input  logic [1:0]   e_state2,
    input  logic [12:0]  e_pretgt2,
    output logic [10:0]  w_addr,
    output logic [17:0]  w_data,
    output logic         wen,
    output logic         drop
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [IDX_W-1:0]   idx1, idx2;
    logic [TAG_W-1:0]   tag1, tag2;
    lane_res_t          r1, r2;
    logic               collide;
    logic               m2;
    logic [1:0]         s2;
    logic [PC_W-1:0]    p2;
    logic               req1, req2;
    logic [UPD_W-1:0]   u1, u2;
    logic               a_v, b_v;
    logic [UPD_W-1:0]   a_d;
    logic               push1, push2, pop;
    logic [UPD_W-1:0]   head;
    logic               empty;
    logic [CW-1:0]      free;

    logic [IDX_W-1:0]   w_addr_q, w_addr_d;
    logic [ENTRY_W-1:0] w_data_q, w_data_d;
    logic               wen_q, wen_d;
    logic               drop_q, drop_d;

    always_comb begin
        idx1    = e_pc1[IDX_W-1:0];
        idx2    = e_pc2[IDX_W-1:0];
        tag1    = e_pc1[PC_W-1:IDX_W];
        tag2    = e_pc2[PC_W-1:IDX_W];
        collide = e_valid1 && e_valid2 && (idx1 == idx2);

        r1 = eval_lane(e_match1, e_state1, e_pretgt1, e_taken1, e_target1, tag1);

        // On a same-index pair lane 2 sees lane 1's result as its lookup,
        // as if lane 1 had already been written to the table.
        m2 = e_match2;
        s2 = e_state2;
        p2 = e_pretgt2;
        if (collide && r1.wr) begin
            m2 = 1'b1;
            s2 = r1.entry[STATE_HI:STATE_LO];
            p2 = r1.entry[TGT_HI:TGT_LO];
        end
        r2 = eval_lane(m2, s2, p2, e_taken2, e_target2, tag2);

        if (collide) begin
            req1 = r1.wr || r2.wr;
            u1   = {idx1, r2.wr ? r2.entry : r1.entry};
            req2 = 1'b0;
        end else begin
            req1 = e_valid1 && r1.wr;
            u1   = {idx1, r1.entry};
            req2 = e_valid2 && r2.wr;
        end
        u2 = {idx2, r2.entry};

        // Compact requests onto push1 first so a single slot goes to the
        // older lane and lane 2 is the first to be dropped.
        a_v   = req1 || req2;
        a_d   = req1 ? u1 : u2;
        b_v   = req1 && req2;
        pop   = !empty;
        push1 = a_v && (free >= CW'(1));
        push2 = b_v && (free >= CW'(2));

        drop_d   = (a_v && !push1) || (b_v && !push2);
        wen_d    = pop;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (pop) begin
            w_addr_d = head[UPD_W-1:ENTRY_W];
            w_data_d = head[ENTRY_W-1:0];
        end
    end

    pu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push1 (push1),
        .din1  (a_d),
        .push2 (push2),
        .din2  (u2),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .free  (free)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_addr_q <= '0;
            w_data_q <= '0;
            wen_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            wen_q    <= wen_d;
            drop_q   <= drop_d;
        end
    end

    assign w_addr = w_addr_q;
    assign w_data = w_data_q;
    assign wen    = wen_q;
    assign drop   = drop_q;

endmodule

// File: tb/tb_predict_update.sv
// tb_predict_update: directed self-checking bench for predict_update
// (DEPTH=4). Inputs change 1 time unit after the rising edge and outputs
// are checked at that same point, away from the active edge.
module tb_predict_update;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        e_valid1, e_valid2;
    logic [12:0] e_pc1, e_pc2;
    logic        e_taken1, e_taken2;
    logic [12:0] e_target1, e_target2;
    logic        e_match1, e_match2;
    logic [1:0]  e_state1, e_state2;
    logic [12:0] e_pretgt1, e_pretgt2;
    logic [10:0] w_addr;
    logic [17:0] w_data;
    logic        wen;
    logic        drop;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    predict_update #(
        .DEPTH (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .e_valid1  (e_valid1),
        .e_pc1     (e_pc1),
        .e_taken1  (e_taken1),
        .e_target1 (e_target1),
        .e_match1  (e_match1),
        .e_state1  (e_state1),
        .e_pretgt1 (e_pretgt1),
        .e_valid2  (e_valid2),
        .e_pc2     (e_pc2),
        .e_taken2  (e_taken2),
        .e_target2 (e_target2),
        .e_match2  (e_match2),
        .e_state2  (e_state2),
        .e_pretgt2 (e_pretgt2),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .wen       (wen),
        .drop      (drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic lane1(input logic [12:0] pc, input logic tk, input logic [12:0] tgt,
                         input logic m, input logic [1:0] st, input logic [12:0] pt);
        e_valid1 = 1'b1; e_pc1 = pc; e_taken1 = tk; e_target1 = tgt;
        e_match1 = m; e_state1 = st; e_pretgt1 = pt;
    endtask

    task automatic lane2(input logic [12:0] pc, input logic tk, input logic [12:0] tgt,
                         input logic m, input logic [1:0] st, input logic [12:0] pt);
        e_valid2 = 1'b1; e_pc2 = pc; e_taken2 = tk; e_target2 = tgt;
        e_match2 = m; e_state2 = st; e_pretgt2 = pt;
    endtask

    task automatic idle();
        e_valid1 = 1'b0; e_pc1 = '0; e_taken1 = 1'b0; e_target1 = '0;
        e_match1 = 1'b0; e_state1 = '0; e_pretgt1 = '0;
        e_valid2 = 1'b0; e_pc2 = '0; e_taken2 = 1'b0; e_target2 = '0;
        e_match2 = 1'b0; e_state2 = '0; e_pretgt2 = '0;
    endtask

    initial begin
        logic [17:0] ed;
        logic [12:0] pc;
        logic [12:0] tg;

        idle();
        // Reset values
        tick();
        tick();
        chk("rst_wen",    32'(wen),    32'd0);
        chk("rst_addr",   32'(w_addr), 32'd0);
        chk("rst_data",   32'(w_data), 32'd0);
        chk("rst_drop",   32'(drop),   32'd0);
        RST = 1'b0;
        tick();

        // Miss allocate, 2-cycle latency
        lane1(13'h0805, 1'b1, 13'h0100, 1'b0, 2'd0, 13'h0000);
        tick();
        idle();
        chk("alloc_early", 32'(wen), 32'd0);
        tick();
        ed = {1'b1, 2'b10, 2'b01, 13'h0100};
        chk("alloc_wen",  32'(wen),    32'd1);
        chk("alloc_addr", 32'(w_addr), 32'h005);
        chk("alloc_data", 32'(w_data), 32'(ed));
        tick();
        chk("alloc_once", 32'(wen), 32'd0);

        // Saturated taken, same target: no write
        lane1(13'h0030, 1'b1, 13'h0123, 1'b1, 2'd3, 13'h0123);
        tick();
        idle();
        repeat (4) begin
            tick();
            chk("elide_taken", 32'(wen), 32'd0);
        end

        // Saturated not-taken: no write
        lane1(13'h0031, 1'b0, 13'h0555, 1'b1, 2'd0, 13'h0321);
        tick();
        idle();
        repeat (4) begin
            tick();
            chk("elide_ntaken", 32'(wen), 32'd0);
        end

        // Decrement keeps looked-up target
        lane1(13'h0042, 1'b0, 13'h0999, 1'b1, 2'd2, 13'h0200);
        tick();
        idle();
        tick();
        ed = {1'b1, 2'b01, 2'b00, 13'h0200};
        chk("dec_wen",  32'(wen),    32'd1);
        chk("dec_addr", 32'(w_addr), 32'h042);
        chk("dec_data", 32'(w_data), 32'(ed));
        tick();
        chk("dec_once", 32'(wen), 32'd0);

        // Same-index collision merges into one write
        lane1(13'h0010, 1'b1, 13'h0040, 1'b1, 2'd1, 13'h0040);
        lane2(13'h0010, 1'b1, 13'h0044, 1'b1, 2'd1, 13'h0040);
        tick();
        idle();
        tick();
        ed = {1'b1, 2'b11, 2'b00, 13'h0044};
        chk("coll_wen",  32'(wen),    32'd1);
        chk("coll_addr", 32'(w_addr), 32'h010);
        chk("coll_data", 32'(w_data), 32'(ed));
        tick();
        chk("coll_once", 32'(wen), 32'd0);
        chk("coll_drop", 32'(drop), 32'd0);

        // Overflow: pairs of allocations U(2c), U(2c+1) for 4 cycles.
        // Occupancy after each edge 2,3,4,4: the 4th cycle keeps U6 and
        // drops U7. Writes U0..U6 follow in order, one per cycle.
        for (int e = 0; e < 9; e++) begin
            if (e < 4) begin
                pc = 13'h0100 + 13'(2 * e);
                tg = 13'h0A00 + 13'(2 * e);
                lane1(pc, 1'b1, tg, 1'b0, 2'd0, 13'h0000);
                lane2(pc + 13'd1, 1'b1, tg + 13'd1, 1'b0, 2'd0, 13'h0000);
            end else begin
                idle();
            end
            tick();
            chk("ovf_drop", 32'(drop), (e == 3) ? 32'd1 : 32'd0);
            if (e >= 1 && e <= 7) begin
                ed = {1'b1, 2'b10, 2'b00, 13'h0A00 + 13'(e - 1)};
                chk("ovf_wen",  32'(wen),    32'd1);
                chk("ovf_addr", 32'(w_addr), 32'h100 + 32'(e - 1));
                chk("ovf_data", 32'(w_data), 32'(ed));
            end else begin
                chk("ovf_idle", 32'(wen), 32'd0);
            end
        end
        idle();
        tick();
        chk("ovf_end", 32'(wen), 32'd0);

        // Reset mid-drain with 3 entries queued
        lane1(13'h0200, 1'b1, 13'h0300, 1'b0, 2'd0, 13'h0000);
        lane2(13'h0201, 1'b1, 13'h0301, 1'b0, 2'd0, 13'h0000);
        tick();
        lane1(13'h0202, 1'b1, 13'h0302, 1'b0, 2'd0, 13'h0000);
        lane2(13'h0203, 1'b1, 13'h0303, 1'b0, 2'd0, 13'h0000);
        tick();
        idle();
        chk("mid_wen",  32'(wen),    32'd1);
        chk("mid_addr", 32'(w_addr), 32'h200);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_wen",  32'(wen),    32'd0);
        chk("mid_rst_addr", 32'(w_addr), 32'd0);
        chk("mid_rst_data", 32'(w_data), 32'd0);
        tick();
        RST = 1'b0;
        repeat (5) begin
            tick();
            chk("post_rst_wen", 32'(wen), 32'd0);
        end
        chk("post_rst_drop", 32'(drop), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
